miner_dispatcher: RTL and testbench

Initiator side of the miner handshake: drives one miner instance with a 640-bit block header, releases its reset, waits for done, and checks the 256-bit result against a target. Sweeps the nonce field, header bits [31:0], from a start value to an end value. Stops on the first hash strictly below target, or when the range is exhausted. Sits between host/job logic and a miner instance, replacing bench-driven stimulus.

---
 rtl/miner_dispatcher_if.sv | 21 ++
 rtl/miner_dispatcher.sv | 192 +++++++++++++++++++
 tb/tb_miner_dispatcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_dispatcher_if.sv
// Handshake bundle between the dispatcher (master) and one miner instance (slave).
interface miner_dispatcher_if;
    logic [639:0] miner_block;
    logic         miner_rst;
    logic [255:0] miner_hashed;
    logic         miner_done;

    modport master (
        output miner_block,
        output miner_rst,
        input  miner_hashed,
        input  miner_done
    );

    modport slave (
        input  miner_block,
        input  miner_rst,
        output miner_hashed,
        output miner_done
    );
endinterface

// File: rtl/miner_dispatcher.sv
// Miner dispatcher: sweeps the nonce field of a block header through one miner
// instance and reports the first hash strictly below target, or exhaustion/timeout.
module miner_dispatcher #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_WAIT   = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [639:0]        header_in,
    input  logic [255:0]        target,
    input  logic [31:0]         nonce_start,
    input  logic [31:0]         nonce_end,
    output logic                busy,
    miner_dispatcher_if.master  miner,
    output logic                result_valid,
    output logic                result_found,
    output logic [31:0]         result_nonce,
    output logic [255:0]        result_hash,
    output logic [31:0]         attempts,
    output logic                timeout_err
);

    localparam int unsigned LOAD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [LOAD_W-1:0]   load_cnt, load_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
    logic [639:0]        block_q, block_d;
    logic                mrst_q, mrst_d;
    logic [255:0]        target_q, target_d;
    logic [31:0]         nonce_end_q, nonce_end_d;
    logic                busy_d;
    logic                valid_d;
    logic                found_d;
    logic [31:0]         rnonce_d;
    logic [255:0]        rhash_d;
    logic [31:0]         attempts_d;
    logic                terr_d;
    logic                hit;

    assign miner.miner_block = block_q;
    assign miner.miner_rst   = mrst_q;

    // Captured hash against latched target; equality counts as a miss.
    assign hit = (result_hash < target_q);

    // Next-state and next-register values for the whole dispatcher.
    always_comb begin
        state_d     = state;
        load_cnt_d  = load_cnt;
        wait_cnt_d  = wait_cnt;
        block_d     = block_q;
        target_d    = target_q;
        nonce_end_d = nonce_end_q;
        busy_d      = busy;
        valid_d     = 1'b0;
        found_d     = result_found;
        rnonce_d    = result_nonce;
        rhash_d     = result_hash;
        attempts_d  = attempts;
        terr_d      = timeout_err;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d         = LOAD;
                    busy_d          = 1'b1;
                    load_cnt_d      = '0;
                    block_d         = header_in;
                    block_d[31:0]   = nonce_start;
                    target_d        = target;
                    nonce_end_d     = nonce_end;
                    attempts_d      = '0;
                    terr_d          = 1'b0;
                    found_d         = 1'b0;
                    rnonce_d        = '0;
                    rhash_d         = '0;
                end
            end
            LOAD: begin
                if (load_cnt == LOAD_W'(RST_CYCLES - 1)) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt + LOAD_W'(1);
                end
            end
            RUN: begin
                if (miner.miner_done) begin
                    rhash_d    = miner.miner_hashed;
                    attempts_d = (attempts == 32'hFFFF_FFFF) ? attempts : attempts + 32'd1;
                    state_d    = CHECK;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    terr_d   = 1'b1;
                    valid_d  = 1'b1;
                    found_d  = 1'b0;
                    rnonce_d = block_q[31:0];
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
            end
            CHECK: begin
                if (hit) begin
                    valid_d  = 1'b1;
                    found_d  = 1'b1;
                    rnonce_d = block_q[31:0];
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (block_q[31:0] == nonce_end_q) begin
                    valid_d  = 1'b1;
                    found_d  = 1'b0;
                    rnonce_d = nonce_end_q;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    block_d[31:0] = block_q[31:0] + 32'd1;
                    load_cnt_d    = '0;
                    state_d       = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over everything else; results and counters keep their values.
        if (abort && (state != IDLE)) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            valid_d    = 1'b0;
            block_d    = block_q;
            found_d    = result_found;
            rnonce_d   = result_nonce;
            rhash_d    = result_hash;
            attempts_d = attempts;
            terr_d     = timeout_err;
        end

        // Miner is held in reset except while an attempt is running or being checked.
        mrst_d = !((state_d == RUN) || (state_d == CHECK));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_cnt     <= '0;
            wait_cnt     <= '0;
            block_q      <= '0;
            mrst_q       <= 1'b1;
            target_q     <= '0;
            nonce_end_q  <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_found <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
            attempts     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_d;
            load_cnt     <= load_cnt_d;
            wait_cnt     <= wait_cnt_d;
            block_q      <= block_d;
            mrst_q       <= mrst_d;
            target_q     <= target_d;
            nonce_end_q  <= nonce_end_d;
            busy         <= busy_d;
            result_valid <= valid_d;
            result_found <= found_d;
            result_nonce <= rnonce_d;
            result_hash  <= rhash_d;
            attempts     <= attempts_d;
            timeout_err  <= terr_d;
        end
    end

endmodule

// File: tb/tb_miner_dispatcher.sv
// Bench for miner_dispatcher: directed scenarios plus randomized jobs against a sweep model.
module tb_miner_dispatcher;

    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned MAX_WAIT   = 256;
    localparam int unsigned MINER_LAT  = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [639:0] header_in = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         busy;
    logic         result_valid;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [31:0]  attempts;
    logic         timeout_err;

    miner_dispatcher_if mif ();

    miner_dispatcher #(
        .RST_CYCLES(RST_CYCLES),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .header_in   (header_in),
        .target      (target),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .busy        (busy),
        .miner       (mif),
        .result_valid(result_valid),
        .result_found(result_found),
        .result_nonce(result_nonce),
        .result_hash (result_hash),
        .attempts    (attempts),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Miner model: hash = nonce, done (level) after MINER_LAT cycles out of reset.
    logic       never_done = 1'b0;
    logic [6:0] mcnt;
    always_ff @(posedge clk) begin
        if (mif.miner_rst) begin
            mcnt           <= '0;
            mif.miner_done <= 1'b0;
        end else if (!never_done && !mif.miner_done) begin
            if (mcnt == 7'(MINER_LAT - 1)) begin
                mif.miner_done   <= 1'b1;
                mif.miner_hashed <= {224'h0, mif.miner_block[31:0]};
            end else begin
                mcnt <= mcnt + 7'd1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Values observed by wait_result
    logic         got_valid;
    logic         cap_found, cap_busy, cap_terr;
    logic [31:0]  cap_nonce, cap_attempts;
    logic [255:0] cap_hash;
    int           run_cycles;
    logic [31:0]  tried_q[$];
    int           runs_q[$];
    logic [639:0] job_hdr;

    // Expected values from the model
    logic         exp_found;
    logic [31:0]  exp_nonce, exp_att;
    logic [255:0] exp_hash;
    logic [31:0]  exp_q[$];

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sweep model: try nonces from s upward (mod 2^32) until hash<target or nonce==e.
    task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
        logic [31:0] n;
        n = s;
        exp_att = 0;
        exp_found = 1'b0;
        exp_nonce = '0;
        exp_hash = '0;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(n);
            exp_att = exp_att + 1;
            exp_hash = {224'h0, n};
            if (exp_hash < tgt) begin
                exp_found = 1'b1;
                exp_nonce = n;
                break;
            end
            if (n == e) begin
                exp_nonce = e;
                break;
            end
            n = n + 32'd1;
        end
    endtask

    function automatic logic [639:0] rand_hdr();
        logic [639:0] h;
        for (int w = 0; w < 20; w++) h[w*32 +: 32] = $urandom;
        return h;
    endfunction

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 640'(busy), 640'(1'b1));
    endtask

    // Watch the miner handshake until result_valid or the cycle budget runs out.
    task automatic wait_result(input int budget, input int poke_at);
        int           cyc;
        int           hi_len;
        logic         prev_rst;
        logic [639:0] blk0;
        cyc = 0;
        hi_len = 0;
        prev_rst = 1'b1;
        blk0 = '0;
        got_valid = 1'b0;
        run_cycles = 0;
        tried_q.delete();
        runs_q.delete();
        while (cyc < budget) begin
            if (result_valid) begin
                got_valid    = 1'b1;
                cap_found    = result_found;
                cap_nonce    = result_nonce;
                cap_hash     = result_hash;
                cap_attempts = attempts;
                cap_busy     = busy;
                cap_terr     = timeout_err;
                break;
            end
            if (mif.miner_rst) begin
                hi_len++;
            end else begin
                run_cycles++;
                if (prev_rst) begin
                    runs_q.push_back(hi_len);
                    hi_len = 0;
                    tried_q.push_back(mif.miner_block[31:0]);
                    blk0 = mif.miner_block;
                    check("hdr_field", {mif.miner_block[639:32], 32'h0}, {job_hdr[639:32], 32'h0});
                end else begin
                    check("block_stable", mif.miner_block, blk0);
                end
            end
            prev_rst = mif.miner_rst;
            if (poke_at != 0 && cyc == poke_at) begin
                start = 1'b1;
                header_in = ~header_in;
                nonce_start = 32'h5555_0000;
                nonce_end = 32'h5555_0001;
                target = '1;
            end else if (poke_at != 0 && cyc == poke_at + 1) begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        assert (got_valid) else begin
            n_fail++;
            $error("FAIL result_wait: observed no result_valid expected pulse within %0d cycles", budget);
        end
    endtask

    task automatic do_job(input string tag, input logic [639:0] hdr, input logic [31:0] s,
                          input logic [31:0] e, input logic [255:0] tgt, input int poke_at);
        logic seen;
        model(s, e, tgt);
        job_hdr = hdr;
        header_in = hdr;
        nonce_start = s;
        nonce_end = e;
        target = tgt;
        launch();
        wait_result(int'(exp_att) * (RST_CYCLES + MINER_LAT + 4) + 40, poke_at);
        check({tag, ".found"}, 640'(cap_found), 640'(exp_found));
        check({tag, ".nonce"}, 640'(cap_nonce), 640'(exp_nonce));
        check({tag, ".hash"}, 640'(cap_hash), 640'(exp_hash));
        check({tag, ".attempts"}, 640'(cap_attempts), 640'(exp_att));
        check({tag, ".busy_at_pulse"}, 640'(cap_busy), 640'(1'b0));
        check({tag, ".timeout_err"}, 640'(cap_terr), 640'(1'b0));
        check({tag, ".n_tried"}, 640'(tried_q.size()), 640'(exp_q.size()));
        for (int k = 0; k < tried_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s.tried[%0d]", tag, k), 640'(tried_q[k]), 640'(exp_q[k]));
        check({tag, ".n_rst_pulses"}, 640'(runs_q.size()), 640'(exp_att));
        foreach (runs_q[k])
            check($sformatf("%s.rst_len[%0d]", tag, k), 640'(runs_q[k]), 640'(RST_CYCLES));
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check({tag, ".single_pulse"}, 640'(seen), 640'(1'b0));
        check({tag, ".nonce_hold"}, 640'(result_nonce), 640'(exp_nonce));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".busy"}, 640'(busy), 640'(1'b0));
        check({tag, ".miner_rst"}, 640'(mif.miner_rst), 640'(1'b1));
        check({tag, ".miner_block"}, mif.miner_block, 640'(0));
        check({tag, ".result_valid"}, 640'(result_valid), 640'(1'b0));
        check({tag, ".result_found"}, 640'(result_found), 640'(1'b0));
        check({tag, ".result_nonce"}, 640'(result_nonce), 640'(0));
        check({tag, ".result_hash"}, 640'(result_hash), 640'(0));
        check({tag, ".attempts"}, 640'(attempts), 640'(0));
        check({tag, ".timeout_err"}, 640'(timeout_err), 640'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        seen;
        int          phase;
        int          cyc;
        logic [31:0] s, e;
        logic [255:0] tgt;
        int unsigned kind;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed jobs
        do_job("first_hit", rand_hdr(), 32'd0, 32'd100, 256'd1, 0);
        do_job("exhaust", rand_hdr(), 32'd10, 32'd20, 256'd5, 0);
        do_job("wrap", rand_hdr(), 32'hFFFF_FFFE, 32'd1, 256'd1, 0);
        do_job("equal", rand_hdr(), 32'd7, 32'd8, 256'd7, 0);
        do_job("single", rand_hdr(), 32'd42, 32'd42, 256'd0, 0);
        do_job("start_busy", rand_hdr(), 32'd5, 32'd7, 256'd0, 30);

        // Timeout: the miner never answers
        never_done = 1'b1;
        job_hdr = rand_hdr();
        header_in = job_hdr;
        nonce_start = 32'h0000_1234;
        nonce_end = 32'h0000_1240;
        target = '1;
        launch();
        wait_result(MAX_WAIT + 40, 0);
        check("timeout.run_cycles", 640'(run_cycles), 640'(MAX_WAIT));
        check("timeout.timeout_err", 640'(cap_terr), 640'(1'b1));
        check("timeout.found", 640'(cap_found), 640'(1'b0));
        check("timeout.nonce", 640'(cap_nonce), 640'(32'h0000_1234));
        check("timeout.attempts", 640'(cap_attempts), 640'(0));
        check("timeout.busy_at_pulse", 640'(cap_busy), 640'(1'b0));
        never_done = 1'b0;
        @(negedge clk);

        // Abort during the second attempt's RUN phase
        job_hdr = rand_hdr();
        header_in = job_hdr;
        nonce_start = 32'd40;
        nonce_end = 32'd90;
        target = '0;
        launch();
        check("abort.terr_cleared", 640'(timeout_err), 640'(1'b0));
        phase = 0;
        cyc = 0;
        while (phase < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (phase == 0 && attempts == 32'd1) phase = 1;
            else if (phase == 1 && mif.miner_rst) phase = 2;
            else if (phase == 2 && !mif.miner_rst) phase = 3;
        end
        check("abort.reached_run", 640'(phase), 640'(3));
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.busy", 640'(busy), 640'(1'b0));
        check("abort.miner_rst", 640'(mif.miner_rst), 640'(1'b1));
        check("abort.result_valid", 640'(result_valid), 640'(1'b0));
        check("abort.attempts_hold", 640'(attempts), 640'(1));
        check("abort.hash_hold", 640'(result_hash), 640'(40));
        check("abort.found_hold", 640'(result_found), 640'(1'b0));
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (result_valid || busy) seen = 1'b1;
        end
        check("abort.quiet", 640'(seen), 640'(1'b0));

        // Reset asserted mid-RUN takes effect without a clock edge
        job_hdr = rand_hdr();
        header_in = job_hdr;
        nonce_start = 32'd3;
        nonce_end = 32'd9;
        target = '0;
        launch();
        cyc = 0;
        while (mif.miner_rst && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset.reached_run", 640'(mif.miner_rst), 640'(1'b0));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (result_valid || busy) seen = 1'b1;
        end
        check("midreset.quiet", 640'(seen), 640'(1'b0));

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            s = (j % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            e = s + 32'($urandom_range(0, 5));
            kind = $urandom_range(0, 2);
            if (kind == 0)      tgt = {224'h0, s + 32'($urandom_range(0, 7))};
            else if (kind == 1) tgt = {$urandom, 224'h0};
            else                tgt = '0;
            do_job($sformatf("rand%0d", j), rand_hdr(), s, e, tgt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
